// File: rtl/mem_copy_dma.sv
// rtl/mem_copy_dma.sv - block-copy engine driving one port of the shared data RAM
//
// Purpose: copies N words from a source base to a destination base.
// Each word takes one READ cycle, then one WRITE cycle. Completion is
// signalled by a one-cycle done pulse.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_start            copy request, sampled only while idle
//   i_src_addr         source base, latched on accepted start
//   i_dst_addr         destination base, latched on accepted start
//   i_length           word count, latched on accepted start
//                      saturates at 2^ADDR_W
//   o_busy             copy in progress (READ/WRITE)
//   o_done             one-cycle completion pulse
//   o_words_done       words written in the current or last copy
//   o_ram_read_en      RAM port read_en
//   o_ram_write_en     RAM port write_en
//   o_ram_addr         RAM port addr
//   o_ram_wdata        RAM port Data_in, always equal to i_ram_rdata
//   i_ram_rdata        RAM port Data_out
module mem_copy_dma #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_src_addr,
   input  logic [ADDR_W-1:0] i_dst_addr,
   input  logic [ADDR_W:0]   i_length,
   output logic              o_busy,
   output logic              o_done,
   output logic [ADDR_W:0]   o_words_done,
   output logic              o_ram_read_en,
   output logic              o_ram_write_en,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_wdata,
   input  logic [DATA_W-1:0] i_ram_rdata
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Largest copy is the whole address space.
   localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [ADDR_W:0]   r_len;
   logic [ADDR_W:0]   r_idx;
   logic [ADDR_W:0]   r_words_done;
   logic [ADDR_W:0]   w_len_sat;
   logic [ADDR_W:0]   w_idx_inc;

   assign w_len_sat    = (i_length > MAX_LEN) ? MAX_LEN : i_length;
   assign w_idx_inc    = r_idx + (ADDR_W+1)'(1);
   assign o_words_done = r_words_done;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_src        <= '0;
         r_dst        <= '0;
         r_len        <= '0;
         r_idx        <= '0;
         r_words_done <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_src        <= i_src_addr;
                  r_dst        <= i_dst_addr;
                  r_len        <= w_len_sat;
                  r_idx        <= '0;
                  r_words_done <= '0;
               end
            end
            S_WRITE: begin
               r_idx        <= w_idx_inc;
               r_words_done <= r_words_done + (ADDR_W+1)'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next         = r_state;
      o_busy         = 1'b0;
      o_done         = 1'b0;
      o_ram_read_en  = 1'b0;
      o_ram_write_en = 1'b0;
      o_ram_addr     = '0;
      // In WRITE, read_en is low, so the RAM keeps its latched read address.
      // Data_out is therefore still the word fetched in the preceding READ.
      o_ram_wdata    = i_ram_rdata;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_next = (w_len_sat == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            o_busy        = 1'b1;
            o_ram_read_en = 1'b1;
            o_ram_addr    = r_src + r_idx[ADDR_W-1:0];
            w_next        = S_WRITE;
         end
         S_WRITE: begin
            o_busy         = 1'b1;
            o_ram_write_en = 1'b1;
            o_ram_addr     = r_dst + r_idx[ADDR_W-1:0];
            w_next         = (w_idx_inc == r_len) ? S_DONE : S_READ;
         end
         S_DONE: begin
            o_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb/tb_mem_copy_dma.sv - directed self-checking bench for mem_copy_dma
module tb_mem_copy_dma;
   localparam int ADDR_W = 9;
   localparam int DATA_W = 16;

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic              i_start;
   logic [ADDR_W-1:0] i_src_addr;
   logic [ADDR_W-1:0] i_dst_addr;
   logic [ADDR_W:0]   i_length;
   logic              o_busy;
   logic              o_done;
   logic [ADDR_W:0]   o_words_done;
   logic              o_ram_read_en;
   logic              o_ram_write_en;
   logic [ADDR_W-1:0] o_ram_addr;
   logic [DATA_W-1:0] o_ram_wdata;
   logic [DATA_W-1:0] i_ram_rdata;

   always #5 i_clk = ~i_clk;

   mem_copy_dma #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_start        (i_start),
      .i_src_addr     (i_src_addr),
      .i_dst_addr     (i_dst_addr),
      .i_length       (i_length),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_words_done   (o_words_done),
      .o_ram_read_en  (o_ram_read_en),
      .o_ram_write_en (o_ram_write_en),
      .o_ram_addr     (o_ram_addr),
      .o_ram_wdata    (o_ram_wdata),
      .i_ram_rdata    (i_ram_rdata)
   );

   // RAM port model: registered read address, combinational data out.
   // A second (backdoor) port preloads words.
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic [ADDR_W-1:0] r_raddr = '0;
   logic              bd_we = 1'b0;
   logic [ADDR_W-1:0] bd_addr = '0;
   logic [DATA_W-1:0] bd_data = '0;

   always @(posedge i_clk) begin
      if (bd_we)          mem[bd_addr]    <= bd_data;
      if (o_ram_write_en) mem[o_ram_addr] <= o_ram_wdata;
      if (o_ram_read_en)  r_raddr         <= o_ram_addr;
   end
   assign i_ram_rdata = mem[r_raddr];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      step();
      bd_we = 1'b0;
   endtask

   int                c_done, n_done, n_busy, n_wr, n_rd;
   logic [ADDR_W-1:0] rd_log [0:1023];
   logic [ADDR_W-1:0] wr_log [0:1023];
   logic [DATA_W-1:0] wd_log [0:1023];

   // Issues one start and observes cycles 1..window after the accepting edge.
   // A nonzero restart_at pulses a competing start during that cycle.
   task automatic run_copy(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                           input logic [ADDR_W:0] l, input int window, input int restart_at);
      c_done = 0; n_done = 0; n_busy = 0; n_wr = 0; n_rd = 0;
      i_src_addr = s; i_dst_addr = d; i_length = l; i_start = 1'b1;
      step();
      i_start = 1'b0;
      for (int c = 1; c <= window; c++) begin
         if (o_busy) n_busy++;
         if (o_ram_read_en) begin rd_log[n_rd] = o_ram_addr; n_rd++; end
         if (o_ram_write_en) begin
            wr_log[n_wr] = o_ram_addr; wd_log[n_wr] = o_ram_wdata; n_wr++;
         end
         if (o_done) begin n_done++; if (c_done == 0) c_done = c; end
         if (c == restart_at) begin
            i_start = 1'b1; i_src_addr = 9'h0AA; i_dst_addr = 9'h0BB; i_length = 10'd7;
         end else begin
            i_start = 1'b0;
         end
         step();
      end
      i_start = 1'b0;
   endtask

   initial begin
      i_rst = 1'b1; i_start = 1'b0; i_src_addr = '0; i_dst_addr = '0; i_length = '0;
      step(); step();
      check("rst_busy",   o_busy, 0);
      check("rst_done",   o_done, 0);
      check("rst_wd",     o_words_done, 0);
      check("rst_rd_en",  o_ram_read_en, 0);
      check("rst_wr_en",  o_ram_write_en, 0);
      check("rst_addr",   o_ram_addr, 0);
      i_rst = 1'b0;

      // Basic copy
      poke(9'h010, 16'hA1A1); poke(9'h011, 16'hB2B2);
      poke(9'h012, 16'hC3C3); poke(9'h013, 16'hD4D4);
      run_copy(9'h010, 9'h100, 10'd4, 11, 0);
      check("basic_done_cyc", c_done, 9);
      check("basic_n_done",   n_done, 1);
      check("basic_busy",     n_busy, 8);
      check("basic_wr",       n_wr, 4);
      check("basic_wd",       o_words_done, 4);
      check("basic_wdata2",   wd_log[2], 16'hC3C3);
      check("basic_m100",     mem[9'h100], 16'hA1A1);
      check("basic_m101",     mem[9'h101], 16'hB2B2);
      check("basic_m102",     mem[9'h102], 16'hC3C3);
      check("basic_m103",     mem[9'h103], 16'hD4D4);

      // Zero length
      run_copy(9'h010, 9'h180, 10'd0, 3, 0);
      check("zero_done_cyc", c_done, 1);
      check("zero_n_done",   n_done, 1);
      check("zero_busy",     n_busy, 0);
      check("zero_wr",       n_wr, 0);
      check("zero_rd",       n_rd, 0);
      check("zero_wd",       o_words_done, 0);

      // Address wrap
      poke(9'h1FE, 16'h1E1E); poke(9'h1FF, 16'h1F1F);
      poke(9'h000, 16'h0000); poke(9'h001, 16'h0101);
      run_copy(9'h1FE, 9'h020, 10'd4, 11, 0);
      check("wrap_rd0", rd_log[0], 9'h1FE);
      check("wrap_rd1", rd_log[1], 9'h1FF);
      check("wrap_rd2", rd_log[2], 9'h000);
      check("wrap_rd3", rd_log[3], 9'h001);
      check("wrap_wr3", wr_log[3], 9'h023);
      check("wrap_m20", mem[9'h020], 16'h1E1E);
      check("wrap_m21", mem[9'h021], 16'h1F1F);
      check("wrap_m23", mem[9'h023], 16'h0101);

      // Length saturation: 600 requested, 512 copied
      run_copy(9'h040, 9'h040, 10'd600, 1027, 0);
      check("sat_done_cyc", c_done, 1025);
      check("sat_n_done",   n_done, 1);
      check("sat_wr",       n_wr, 512);
      check("sat_busy",     n_busy, 1024);
      check("sat_wd",       o_words_done, 512);

      // Overlapping forward copy propagates the first word
      poke(9'h010, 16'h1111); poke(9'h011, 16'h2222); poke(9'h012, 16'h3333);
      run_copy(9'h010, 9'h011, 10'd3, 9, 0);
      check("ovl_done_cyc", c_done, 7);
      check("ovl_m11", mem[9'h011], 16'h1111);
      check("ovl_m12", mem[9'h012], 16'h1111);
      check("ovl_m13", mem[9'h013], 16'h1111);

      // Start while busy is ignored
      poke(9'h030, 16'h3030); poke(9'h031, 16'h3131);
      poke(9'h032, 16'h3232); poke(9'h033, 16'h3333);
      poke(9'h0BB, 16'hDEAD);
      run_copy(9'h030, 9'h140, 10'd4, 14, 3);
      check("sb_done_cyc", c_done, 9);
      check("sb_n_done",   n_done, 1);
      check("sb_wr",       n_wr, 4);
      check("sb_wr3",      wr_log[3], 9'h143);
      check("sb_m143",     mem[9'h143], 16'h3333);
      check("sb_mBB",      mem[9'h0BB], 16'hDEAD);
      check("sb_wd",       o_words_done, 4);

      // Reset during the third WRITE of a 5-word copy
      poke(9'h050, 16'h5050); poke(9'h051, 16'h5151); poke(9'h052, 16'h5252);
      poke(9'h053, 16'h5353); poke(9'h054, 16'h5454);
      poke(9'h163, 16'h0000); poke(9'h164, 16'h0000);
      i_src_addr = 9'h050; i_dst_addr = 9'h160; i_length = 10'd5; i_start = 1'b1;
      step();
      i_start = 1'b0;
      for (int c = 1; c < 6; c++) step();
      check("mr_wr_en", o_ram_write_en, 1);
      check("mr_addr",  o_ram_addr, 9'h162);
      check("mr_wd",    o_words_done, 2);
      i_rst = 1'b1; i_start = 1'b1;
      step();
      i_rst = 1'b0; i_start = 1'b0;
      check("mr_busy",  o_busy, 0);
      check("mr_done",  o_done, 0);
      check("mr_wd0",   o_words_done, 0);
      check("mr_rd_en", o_ram_read_en, 0);
      check("mr_wr_en0", o_ram_write_en, 0);
      check("mr_addr0", o_ram_addr, 0);
      step(); step();
      check("mr_idle", o_busy, 0);
      check("mr_m160", mem[9'h160], 16'h5050);
      check("mr_m161", mem[9'h161], 16'h5151);
      check("mr_m163", mem[9'h163], 16'h0000);
      check("mr_m164", mem[9'h164], 16'h0000);

      run_copy(9'h050, 9'h170, 10'd2, 7, 0);
      check("post_done_cyc", c_done, 5);
      check("post_wd",       o_words_done, 2);
      check("post_m171",     mem[9'h171], 16'h5151);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
